// File: rtl/uart_tx_sched.sv
// Arbitrates the single UART transmitter between a buffered CPU byte stream and the memory-dump stream.
// Optional tx_done watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int unsigned FIFO_AW   = 2,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_byte,
    output logic       cpu_full,
    output logic       cpu_empty,
    input  logic       dump_req,
    input  logic [7:0] dump_byte,
    output logic       dump_ack,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       grant_dump,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic       tx_timeout
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Elaboration-time guard on parameter ranges.
    if (FIFO_AW == 0 || TIMEOUT_W < 2) begin : g_bad_params
        $error("uart_tx_sched: FIFO_AW must be >= 1 and TIMEOUT_W >= 2");
    end

    state_t state, state_nxt;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_nxt;
    logic               push, pop, drop;

    logic       prefer_dump, prefer_dump_nxt;
    logic       sel_dump;
    logic       tx_wr_nxt;
    logic [7:0] tx_data_nxt;
    logic       dump_ack_nxt;
    logic       grant_dump_nxt;
    logic       overflow_nxt;

`ifdef UART_TX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 timeout_hit;
    logic                 tx_timeout_q;
    logic                 tx_timeout_nxt;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt       = state;
        tx_wr_nxt       = 1'b0;
        tx_data_nxt     = tx_data;
        dump_ack_nxt    = 1'b0;
        grant_dump_nxt  = grant_dump;
        prefer_dump_nxt = prefer_dump;
        sel_dump        = 1'b0;
        pop             = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
        timeout_hit     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!cpu_empty || dump_req) begin
                    // With both pending, serve whichever source was not served last.
                    sel_dump        = dump_req && (cpu_empty || prefer_dump);
                    pop             = !sel_dump;
                    tx_data_nxt     = sel_dump ? dump_byte : mem[rd_ptr];
                    grant_dump_nxt  = sel_dump;
                    prefer_dump_nxt = !sel_dump;
                    tx_wr_nxt       = 1'b1;
                    state_nxt       = SEND;
                end
            end
            SEND: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    dump_ack_nxt = grant_dump;
                    state_nxt    = IDLE;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (to_cnt == '1) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO occupancy and overflow tracking.
    always_comb begin
        push = cpu_wr && ((count < CW'(DEPTH)) || pop);
        drop = cpu_wr && !push;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (ovf_clear) begin
            overflow_nxt = 1'b0;
        end else begin
            overflow_nxt = overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr       <= 1'b0;
            tx_data     <= 8'h00;
            dump_ack    <= 1'b0;
            busy        <= 1'b0;
            grant_dump  <= 1'b0;
            prefer_dump <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            tx_wr       <= tx_wr_nxt;
            tx_data     <= tx_data_nxt;
            dump_ack    <= dump_ack_nxt;
            busy        <= (state_nxt != IDLE);
            grant_dump  <= grant_dump_nxt;
            prefer_dump <= prefer_dump_nxt;
            overflow    <= overflow_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cpu_full  <= 1'b0;
            cpu_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count     <= count_nxt;
            cpu_full  <= (count_nxt == CW'(DEPTH));
            cpu_empty <= (count_nxt == '0);
        end
    end

    // Storage is not reset; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_byte;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    always_comb begin
        if (timeout_hit) begin
            tx_timeout_nxt = 1'b1;
        end else if (ovf_clear) begin
            tx_timeout_nxt = 1'b0;
        end else begin
            tx_timeout_nxt = tx_timeout_q;
        end
    end

    // Watchdog restarts whenever the FSM enters WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt       <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            if (state == SEND) begin
                to_cnt <= '0;
            end else if (state == WAIT) begin
                to_cnt <= to_cnt + TIMEOUT_W'(1);
            end
            tx_timeout_q <= tx_timeout_nxt;
        end
    end

    assign tx_timeout = tx_timeout_q;
`else
    assign tx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboard of transmitted bytes plus a
// cycle table for the FIFO fill / overflow sequence and hand-written corner cases.
module tb_uart_tx_sched;

    localparam int unsigned FIFO_AW   = 2;
    localparam int unsigned TIMEOUT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_wr;
    logic [7:0] cpu_byte;
    logic       cpu_full;
    logic       cpu_empty;
    logic       dump_req;
    logic [7:0] dump_byte;
    logic       dump_ack;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy;
    logic       grant_dump;
    logic       overflow;
    logic       ovf_clear;
    logic       tx_timeout;

    logic done_auto;
    logic done_man;
    logic auto_done;

    assign tx_done = done_auto | done_man;

    uart_tx_sched #(
        .FIFO_AW  (FIFO_AW),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_wr    (cpu_wr),
        .cpu_byte  (cpu_byte),
        .cpu_full  (cpu_full),
        .cpu_empty (cpu_empty),
        .dump_req  (dump_req),
        .dump_byte (dump_byte),
        .dump_ack  (dump_ack),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .grant_dump(grant_dump),
        .overflow  (overflow),
        .ovf_clear (ovf_clear),
        .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dump;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    // One row per clock: inputs applied, then {tx_wr,busy,dump_ack,cpu_full,cpu_empty,overflow}.
    typedef struct {
        logic       wr;
        logic [7:0] byte_in;
        logic       dreq;
        logic       done;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    int n_chk = 0;
    int n_err = 0;
    int tx_cnt = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] out_vec();
        return {tx_wr, busy, dump_ack, grant_dump, overflow, tx_timeout,
                cpu_full, cpu_empty, tx_data};
    endfunction

    // Scoreboard consumer: every start pulse must match the next expected byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_cnt  = 0;
                ack_cnt = 0;
            end else begin
                if (tx_wr) begin
                    tx_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_tx", {23'd0, grant_dump, tx_data}, 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", {23'd0, grant_dump, tx_data}, {23'd0, e.dump, e.data});
                    end
                end
                if (dump_ack) begin
                    ack_cnt++;
                end
            end
        end
    end

    // Transceiver model: answers each start pulse with tx_done a few cycles later.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_done && tx_wr && rst_n) begin
                repeat (2) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        cpu_wr    = 1'b0;
        cpu_byte  = 8'h00;
        dump_req  = 1'b0;
        dump_byte = 8'h00;
        ovf_clear = 1'b0;
        done_man  = 1'b0;
        auto_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && rst_n) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < bound), 32'd1);
    endtask

    task automatic wait_ack(input string name, input int bound);
        int n;
        n = 0;
        while (!dump_ack && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ack_in_time"}, 32'(dump_ack), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'b110010};
        vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 6'b010100};
        vecs[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 6'b010101};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b010101};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b001101};
        vecs[8]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 6'b110101};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'b010100};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b010100};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'b000100};

        // Reset state.
        do_reset();
        check("reset_outputs", 32'(out_vec()), 32'h0100);

        // CPU bytes back-to-back are sent in order.
        auto_done = 1'b1;
        exp_q.push_back('{1'b0, 8'h41});
        exp_q.push_back('{1'b0, 8'h42});
        exp_q.push_back('{1'b0, 8'h43});
        cpu_wr = 1'b1; cpu_byte = 8'h41;
        @(negedge clk); cpu_byte = 8'h42;
        @(negedge clk); cpu_byte = 8'h43;
        @(negedge clk); cpu_wr = 1'b0;
        wait_drain("t1", 200);
        check("t1_tx_count", 32'(tx_cnt), 32'd3);
        check("t1_cpu_empty", 32'(cpu_empty), 32'd1);
        check("t1_no_ack", 32'(ack_cnt), 32'd0);

        // Single dump byte: start pulse on the next cycle, one-cycle ack.
        do_reset();
        auto_done = 1'b1;
        exp_q.push_back('{1'b1, 8'hA5});
        dump_req = 1'b1; dump_byte = 8'hA5;
        @(negedge clk);
        check("t2_latency", {15'd0, tx_wr, grant_dump, tx_data}, {15'd0, 1'b1, 1'b1, 8'hA5});
        wait_ack("t2", 50);
        dump_req = 1'b0;
        @(negedge clk);
        check("t2_ack_width", 32'(dump_ack), 32'd0);
        check("t2_grant_dump", 32'(grant_dump), 32'd1);
        wait_drain("t2", 50);
        check("t2_ack_count", 32'(ack_cnt), 32'd1);

        // Round robin: CPU first after reset, then dump, then CPU.
        do_reset();
        auto_done = 1'b1;
        exp_q.push_back('{1'b0, 8'h11});
        exp_q.push_back('{1'b1, 8'h99});
        exp_q.push_back('{1'b0, 8'h22});
        cpu_wr = 1'b1; cpu_byte = 8'h11;
        @(negedge clk);
        cpu_byte = 8'h22; dump_req = 1'b1; dump_byte = 8'h99;
        @(negedge clk);
        cpu_wr = 1'b0;
        wait_ack("t3", 100);
        check("t3_ack_after_dump_byte", 32'(tx_cnt), 32'd2);
        dump_req = 1'b0;
        wait_drain("t3", 100);
        check("t3_tx_count", 32'(tx_cnt), 32'd3);
        check("t3_ack_count", 32'(ack_cnt), 32'd1);

        // FIFO fill behind a stalled dump transfer, overflow, push-with-pop on full.
        do_reset();
        dump_byte = 8'h77;
        exp_q.push_back('{1'b1, 8'h77});
        exp_q.push_back('{1'b0, 8'h01});
        exp_q.push_back('{1'b0, 8'h02});
        exp_q.push_back('{1'b0, 8'h03});
        exp_q.push_back('{1'b0, 8'h04});
        exp_q.push_back('{1'b0, 8'h06});
        for (int i = 0; i < 12; i++) begin
            cpu_wr    = vecs[i].wr;
            cpu_byte  = vecs[i].byte_in;
            dump_req  = vecs[i].dreq;
            done_man  = vecs[i].done;
            ovf_clear = vecs[i].clr;
            @(negedge clk);
            check($sformatf("t4_row%0d", i),
                  {26'd0, tx_wr, busy, dump_ack, cpu_full, cpu_empty, overflow},
                  {26'd0, vecs[i].exp});
        end
        cpu_wr = 1'b0; done_man = 1'b0; ovf_clear = 1'b0;
        auto_done = 1'b1;
        wait_drain("t4", 200);
        check("t4_empty_after_drain", 32'(cpu_empty), 32'd1);
        check("t4_overflow_cleared", 32'(overflow), 32'd0);

        // Asynchronous reset in WAIT, then a stray tx_done.
        do_reset();
        exp_q.push_back('{1'b1, 8'h3C});
        dump_req = 1'b1; dump_byte = 8'h3C;
        @(negedge clk);
        dump_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_busy_before_reset", {30'd0, busy, grant_dump}, 32'd3);
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", 32'(out_vec()), 32'h0100);
        @(negedge clk);
        rst_n = 1'b1;
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t5_stray_done_%0d", i), {29'd0, busy, tx_wr, dump_ack}, 32'd0);
        end

        // Missing tx_done: watchdog behaviour depends on the build.
        do_reset();
        exp_q.push_back('{1'b1, 8'h5A});
        dump_req = 1'b1; dump_byte = 8'h5A;
        @(negedge clk);
        dump_req = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
        begin
            int busy_cycles;
            busy_cycles = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (busy) busy_cycles++;
            end
            check("t6_wait_cycles", 32'(busy_cycles), 32'd16);
            check("t6_timeout_flag", {30'd0, tx_timeout, busy}, 32'd2);
            check("t6_no_ack", 32'(ack_cnt), 32'd0);
            ovf_clear = 1'b1;
            @(negedge clk);
            ovf_clear = 1'b0;
            check("t6_timeout_cleared", 32'(tx_timeout), 32'd0);
        end
`else
        repeat (40) @(negedge clk);
        check("t6_holds_wait", {30'd0, busy, tx_timeout}, 32'd2);
        check("t6_no_ack", 32'(ack_cnt), 32'd0);
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        check("t6_late_done_ack", {30'd0, dump_ack, busy}, 32'd2);
`endif
        check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "global timeout");
    end

endmodule
